// File: rtl/nn_bgcluster_rr.sv
// nn_bgcluster_rr -- parametrised burst-gate cluster with round-robin gate enable.
//
// NGATES saturating up/down counters share one stochastic input bit. A
// round-robin selector enables exactly one gate per clock. Each gate output
// sets when its counter reaches MEMSIZE-1, clears when it reaches 0, and
// otherwise holds. A registered vote over the gate outputs with separate
// set/clear thresholds (THRESH_HI / THRESH_LO) produces OUT.
//
// Optional feature macro: NN_BGC_HOLD_EN
//   When defined, an extra HOLD input freezes all state (CLR still clears).
//   When undefined, the block advances on every clock.
module nn_bgcluster_rr #(
   parameter int MEMSIZE    = 16,
   parameter int NGATES     = 3,
   parameter int THRESH_HI  = NGATES,
   parameter int THRESH_LO  = 0,
   parameter bit INIT_STATE = 1'b0
) (
   input  logic                                        CLK,
   input  logic                                        INIT,
   input  logic                                        CLR,
`ifdef NN_BGC_HOLD_EN
   input  logic                                        HOLD,
`endif
   input  logic                                        IN,
   output logic                                        OUT,
   output logic [NGATES-1:0]                           GATES,
   output logic [$clog2(NGATES+1)-1:0]                 VOTES,
   output logic [((NGATES > 1) ? $clog2(NGATES) : 1)-1:0] SEL
);

   localparam int CW = $clog2(MEMSIZE);
   localparam int SW = (NGATES > 1) ? $clog2(NGATES) : 1;
   localparam int VW = $clog2(NGATES + 1);

   localparam logic [CW-1:0] CNT_MAX  = CW'(MEMSIZE - 1);
   localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_INIT = INIT_STATE ? CNT_MAX : CNT_ZERO;

   localparam logic [SW-1:0] SEL_ZERO = {SW{1'b0}};
   localparam logic [SW-1:0] SEL_ONE  = SW'(1);
   localparam logic [SW-1:0] SEL_LAST = SW'(NGATES - 1);

   localparam logic [VW-1:0] VOTE_HI  = VW'(THRESH_HI);
   localparam logic [VW-1:0] VOTE_LO  = VW'(THRESH_LO);

   // Number of gate outputs currently set.
   function automatic logic [VW-1:0] popcount(input logic [NGATES-1:0] vec);
      logic [VW-1:0] sum;
      sum = {VW{1'b0}};
      for (int i = 0; i < NGATES; i++) begin
         sum = sum + VW'(vec[i]);
      end
      return sum;
   endfunction

   logic [CW-1:0]     cnt_r     [NGATES];
   logic [CW-1:0]     cnt_nxt_s [NGATES];
   logic [NGATES-1:0] gates_r;
   logic [NGATES-1:0] gates_nxt_s;
   logic [SW-1:0]     sel_r;
   logic [SW-1:0]     sel_nxt_s;
   logic              out_r;
   logic              out_nxt_s;
   logic [VW-1:0]     votes_s;
   logic              adv_s;

`ifdef NN_BGC_HOLD_EN
   assign adv_s = ~HOLD;
`else
   assign adv_s = 1'b1;
`endif

   assign votes_s = popcount(gates_r);

   // Next counter and hysteretic gate output; only the selected gate moves.
   always_comb begin
      for (int i = 0; i < NGATES; i++) begin
         cnt_nxt_s[i]   = cnt_r[i];
         gates_nxt_s[i] = gates_r[i];
         if (SW'(i) == sel_r) begin
            if (IN) begin
               if (cnt_r[i] < CNT_MAX) begin
                  cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
               end else begin
                  cnt_nxt_s[i] = cnt_r[i];
               end
            end else begin
               if (cnt_r[i] > CNT_ZERO) begin
                  cnt_nxt_s[i] = cnt_r[i] - CNT_ONE;
               end else begin
                  cnt_nxt_s[i] = cnt_r[i];
               end
            end
            if (cnt_nxt_s[i] == CNT_MAX) begin
               gates_nxt_s[i] = 1'b1;
            end else if (cnt_nxt_s[i] == CNT_ZERO) begin
               gates_nxt_s[i] = 1'b0;
            end else begin
               gates_nxt_s[i] = gates_r[i];
            end
         end else begin
            cnt_nxt_s[i]   = cnt_r[i];
            gates_nxt_s[i] = gates_r[i];
         end
      end
   end

   // Round-robin selector: wraps after the last gate with no idle slot.
   always_comb begin
      sel_nxt_s = sel_r;
      if (sel_r == SEL_LAST) begin
         sel_nxt_s = SEL_ZERO;
      end else begin
         sel_nxt_s = sel_r + SEL_ONE;
      end
   end

   // Threshold vote with hysteresis band between THRESH_LO and THRESH_HI.
   always_comb begin
      out_nxt_s = out_r;
      if (votes_s >= VOTE_HI) begin
         out_nxt_s = 1'b1;
      end else if (votes_s <= VOTE_LO) begin
         out_nxt_s = 1'b0;
      end else begin
         out_nxt_s = out_r;
      end
   end

   // State registers: async INIT, then sync CLR, then advance unless frozen.
   always_ff @(posedge CLK or posedge INIT) begin
      if (INIT) begin
         sel_r   <= SEL_ZERO;
         gates_r <= {NGATES{INIT_STATE}};
         out_r   <= INIT_STATE;
         for (int i = 0; i < NGATES; i++) begin
            cnt_r[i] <= CNT_INIT;
         end
      end else if (CLR) begin
         sel_r   <= SEL_ZERO;
         gates_r <= {NGATES{INIT_STATE}};
         out_r   <= INIT_STATE;
         for (int i = 0; i < NGATES; i++) begin
            cnt_r[i] <= CNT_INIT;
         end
      end else if (adv_s) begin
         sel_r   <= sel_nxt_s;
         gates_r <= gates_nxt_s;
         out_r   <= out_nxt_s;
         for (int i = 0; i < NGATES; i++) begin
            cnt_r[i] <= cnt_nxt_s[i];
         end
      end else begin
         sel_r   <= sel_r;
         gates_r <= gates_r;
         out_r   <= out_r;
         for (int i = 0; i < NGATES; i++) begin
            cnt_r[i] <= cnt_r[i];
         end
      end
   end

   assign OUT   = out_r;
   assign GATES = gates_r;
   assign VOTES = votes_s;
   assign SEL   = sel_r;

endmodule

// File: tb/tb_nn_bgcluster_rr.sv
// Testbench for nn_bgcluster_rr: three instances with different parameter
// sets share clock and stimulus; a behavioural model of each cluster is
// compared against the outputs on every falling edge, and directed phases
// add hand-computed expectations. Exercises HOLD when NN_BGC_HOLD_EN is set.
module tb_nn_bgcluster_rr;

   logic CLK = 1'b0;
   logic INIT, CLR, din, hold;

   logic [1:0] sel_a;  logic [2:0] gates_a; logic [1:0] votes_a; logic out_a;
   logic [2:0] sel_b;  logic [4:0] gates_b; logic [2:0] votes_b; logic out_b;
   logic [1:0] sel_c;  logic [2:0] gates_c; logic [1:0] votes_c; logic out_c;

   always #5 CLK = ~CLK;

   nn_bgcluster_rr #(.MEMSIZE(4), .NGATES(3), .THRESH_HI(3), .THRESH_LO(0), .INIT_STATE(1'b0)) dut_a (
      .CLK(CLK), .INIT(INIT), .CLR(CLR),
`ifdef NN_BGC_HOLD_EN
      .HOLD(hold),
`endif
      .IN(din), .OUT(out_a), .GATES(gates_a), .VOTES(votes_a), .SEL(sel_a));

   nn_bgcluster_rr #(.MEMSIZE(2), .NGATES(5), .THRESH_HI(3), .THRESH_LO(1), .INIT_STATE(1'b0)) dut_b (
      .CLK(CLK), .INIT(INIT), .CLR(CLR),
`ifdef NN_BGC_HOLD_EN
      .HOLD(hold),
`endif
      .IN(din), .OUT(out_b), .GATES(gates_b), .VOTES(votes_b), .SEL(sel_b));

   nn_bgcluster_rr #(.MEMSIZE(16), .NGATES(3), .INIT_STATE(1'b1)) dut_c (
      .CLK(CLK), .INIT(INIT), .CLR(CLR),
`ifdef NN_BGC_HOLD_EN
      .HOLD(hold),
`endif
      .IN(din), .OUT(out_c), .GATES(gates_c), .VOTES(votes_c), .SEL(sel_c));

   // Model parameters per instance (a, b, c).
   int ms[3]  = '{4, 2, 16};
   int ng[3]  = '{3, 5, 3};
   int hi[3]  = '{3, 3, 3};
   int lo[3]  = '{0, 1, 0};
   int ist[3] = '{0, 0, 1};

   // Model state.
   int m_cnt[3][5];
   int m_g[3][5];
   int m_sel[3];
   int m_out[3];

   int tests_run = 0;
   int tests_failed = 0;

   task automatic chk(input string name, input int k, input int got, input int exp);
      tests_run++;
      if (got != exp) begin
         tests_failed++;
         $display("FAIL %s inst=%0d got=%0d expected=%0d t=%0t", name, k, got, exp, $time);
      end
   endtask

   task automatic model_reset(input int k);
      m_sel[k] = 0;
      m_out[k] = ist[k];
      for (int i = 0; i < 5; i++) begin
         m_cnt[k][i] = (ist[k] != 0) ? ms[k] - 1 : 0;
         m_g[k][i]   = ist[k];
      end
   endtask

   function automatic int model_votes(input int k);
      int v = 0;
      for (int i = 0; i < ng[k]; i++) v += m_g[k][i];
      return v;
   endfunction

   function automatic int model_gates(input int k);
      int m = 0;
      for (int i = 0; i < ng[k]; i++) m |= (m_g[k][i] << i);
      return m;
   endfunction

   // One rising edge of the cluster, from the rules: vote uses pre-edge gates.
   task automatic model_edge(input int k);
      int s, c, v;
      if (CLR) begin
         model_reset(k);
      end else if (!hold) begin
         v = model_votes(k);
         s = m_sel[k];
         c = m_cnt[k][s];
         if (din) c = (c + 1 > ms[k] - 1) ? ms[k] - 1 : c + 1;
         else     c = (c - 1 < 0) ? 0 : c - 1;
         m_cnt[k][s] = c;
         if (c == ms[k] - 1) m_g[k][s] = 1;
         else if (c == 0)    m_g[k][s] = 0;
         if (v >= hi[k])      m_out[k] = 1;
         else if (v <= lo[k]) m_out[k] = 0;
         m_sel[k] = (s + 1) % ng[k];
      end
   endtask

   task automatic chk_inst(input int k, input int s, input int g, input int v, input int o);
      chk("sel",   k, s, m_sel[k]);
      chk("gates", k, g, model_gates(k));
      chk("votes", k, v, model_votes(k));
      chk("out",   k, o, m_out[k]);
   endtask

   task automatic check_all();
      chk_inst(0, int'(sel_a), int'(gates_a), int'(votes_a), int'(out_a));
      chk_inst(1, int'(sel_b), int'(gates_b), int'(votes_b), int'(out_b));
      chk_inst(2, int'(sel_c), int'(gates_c), int'(votes_c), int'(out_c));
   endtask

   // Advance one clock: model follows the edge, outputs checked on the falling edge.
   task automatic tick();
      @(posedge CLK);
      if (!INIT) begin
         for (int k = 0; k < 3; k++) model_edge(k);
      end
      @(negedge CLK);
      check_all();
   endtask

   int hseq[8] = '{1, 1, 1, 0, 0, 0, 0, 0};
   int saved_sel;

   initial begin
      INIT = 1'b1; CLR = 1'b0; din = 1'b0; hold = 1'b0;
      for (int k = 0; k < 3; k++) model_reset(k);
      @(negedge CLK);
      check_all();
      chk("rst_gates_a", 0, int'(gates_a), 0);
      chk("rst_gates_c", 2, int'(gates_c), 7);
      chk("rst_out_c",   2, int'(out_c),   1);

      // Ramp: IN=1 from INIT release.
      INIT = 1'b0; din = 1'b1;
      for (int e = 1; e <= 10; e++) begin
         tick();
         chk("ramp_sel",   0, int'(sel_a), e % 3);
         chk("ramp_gates", 0, int'(gates_a),
             ((e >= 7) ? 1 : 0) | ((e >= 8) ? 2 : 0) | ((e >= 9) ? 4 : 0));
         chk("ramp_out",   0, int'(out_a), (e >= 10) ? 1 : 0);
      end

      // Decay: IN=0 from saturation.
      din = 1'b0;
      for (int d = 1; d <= 10; d++) begin
         tick();
         if (d == 7)  begin chk("decay_v2", 0, int'(votes_a), 2); chk("decay_o2", 0, int'(out_a), 1); end
         if (d == 8)  begin chk("decay_v1", 0, int'(votes_a), 1); chk("decay_o1", 0, int'(out_a), 1); end
         if (d == 9)  begin chk("decay_g0", 0, int'(gates_a), 0); chk("decay_o0", 0, int'(out_a), 1); end
         if (d == 10) chk("decay_clr", 0, int'(out_a), 0);
      end

      // Hysteresis band on instance b.
      CLR = 1'b1; tick(); CLR = 1'b0;
      chk("clr_sel_b", 1, int'(sel_b), 0);
      for (int e = 1; e <= 8; e++) begin
         din = hseq[e-1][0];
         tick();
         if (e == 4) begin chk("hyst_set_v", 1, int'(votes_b), 3); chk("hyst_set_o", 1, int'(out_b), 1); end
         if (e == 7) begin chk("hyst_hold_v", 1, int'(votes_b), 1); chk("hyst_hold_o", 1, int'(out_b), 1); end
         if (e == 8) chk("hyst_clr_o", 1, int'(out_b), 0);
      end

      // CLR mid-operation, then async INIT between edges.
      for (int n = 0; n < 20; n++) begin din = 1'($urandom_range(0, 1)); tick(); end
      din = 1'b0; CLR = 1'b1; tick(); CLR = 1'b0;
      chk("clr_sel_c",   2, int'(sel_c),   0);
      chk("clr_gates_c", 2, int'(gates_c), 7);
      chk("clr_out_c",   2, int'(out_c),   1);
      for (int n = 0; n < 7; n++) tick();
      #2 INIT = 1'b1;
      for (int k = 0; k < 3; k++) model_reset(k);
      #1 check_all();
      chk("ainit_gates_c", 2, int'(gates_c), 7);
      chk("ainit_sel_a",   0, int'(sel_a),   0);
      tick();
      INIT = 1'b0;

      // Randomised run with rare CLR (and HOLD when present).
      for (int n = 0; n < 3000; n++) begin
         din = 1'($urandom_range(0, 1));
         CLR = ($urandom_range(0, 249) == 0);
`ifdef NN_BGC_HOLD_EN
         hold = ($urandom_range(0, 7) == 0);
`endif
         tick();
      end
      CLR = 1'b0; hold = 1'b0;

`ifdef NN_BGC_HOLD_EN
      // HOLD freezes everything; selector resumes from the frozen value.
      tick();
      saved_sel = m_sel[1];
      hold = 1'b1;
      for (int n = 0; n < 5; n++) begin
         din = ~din;
         tick();
         chk("hold_sel", 1, int'(sel_b), saved_sel);
      end
      hold = 1'b0; din = 1'b0;
      tick();
      chk("hold_resume", 1, int'(sel_b), (saved_sel + 1) % 5);
      hold = 1'b1; CLR = 1'b1;
      tick();
      chk("hold_clr_sel", 1, int'(sel_b), 0);
      chk("hold_clr_g",   2, int'(gates_c), 7);
      hold = 1'b0; CLR = 1'b0;
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
